// File: rtl/fact_ctrl.sv
// Factorial controller: sequences the factorial datapath through load,
// multiply/decrement and termination check, with a go/done/err handshake
// and an iteration watchdog that aborts runs the datapath never finishes.
module fact_ctrl #(
  parameter int ITER_MAX = 15,
  parameter int ITER_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       cnt_out,
  input  logic       in_gt_12,
  output logic [5:0] control_signals,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_MUL   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // control_signals bit map: {en_D, mux_s0, mux_s1, cnt_ld, cnt_ud, cnt_ce}
  localparam logic [5:0] CS_LOAD = 6'b100101;
  localparam logic [5:0] CS_MUL  = 6'b110001;
  localparam logic [5:0] CS_DONE = 6'b001000;

  state_t              r_state;
  state_t              w_next;
  logic                r_go_q;
  logic                w_go_pulse;
  logic [ITER_W-1:0]   r_iter;
  logic                r_timeout;
  logic                w_iter_clr;
  logic                w_iter_inc;
  logic                w_to_set;
  logic                w_to_clr;

  assign w_go_pulse = go & ~r_go_q;

  // Edge detector on go: a held-high go must never retrigger a run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_go_q <= 1'b0;
    else     r_go_q <= go;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Watchdog iteration counter and the cause of the last error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iter    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_iter_clr)      r_iter <= '0;
      else if (w_iter_inc) r_iter <= r_iter + 1'b1;
      if (w_to_set)        r_timeout <= 1'b1;
      else if (w_to_clr)   r_timeout <= 1'b0;
    end
  end

  // Next-state logic and Moore outputs
  always_comb begin
    w_next          = r_state;
    w_iter_clr      = 1'b0;
    w_iter_inc      = 1'b0;
    w_to_set        = 1'b0;
    w_to_clr        = 1'b0;
    control_signals = 6'b000000;
    busy            = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    timeout         = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (r_state == S_DONE) begin
          control_signals = CS_DONE;
          done            = 1'b1;
        end
        if (r_state == S_ERR) begin
          err     = 1'b1;
          timeout = r_timeout;
        end
        // Operand range is judged only at the moment a run is requested
        if (w_go_pulse) begin
          if (in_gt_12) begin
            w_next   = S_ERR;
            w_to_clr = 1'b1;
          end else begin
            w_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        control_signals = CS_LOAD;
        busy            = 1'b1;
        w_iter_clr      = 1'b1;
        w_next          = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (cnt_out) begin
          w_next = S_DONE;
        end else if (r_iter == ITER_W'(ITER_MAX)) begin
          w_next   = S_ERR;
          w_to_set = 1'b1;
        end else begin
          w_next = S_MUL;
        end
      end
      S_MUL: begin
        control_signals = CS_MUL;
        busy            = 1'b1;
        w_iter_inc      = 1'b1;
        w_next          = S_CHECK;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign state = r_state;

endmodule

// File: doc/fact_ctrl.md
Name: fact_ctrl

Overview:
- Control unit that drives the 6-bit control_signals bus of the factorial datapath.
- Consumes the datapath status flags cnt_out and in_gt_12.
- Sequences load / multiply-decrement / check / present-result with a go/done/err handshake toward the top level.
- Includes an iteration watchdog that forces an error if the datapath status never terminates the loop.

Parameters:
- ITER_MAX, 15: maximum MUL iterations allowed per run before a timeout error.
- ITER_W, 4: width of the internal iteration counter; must satisfy 2^ITER_W > ITER_MAX.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- go  input  1  start request, level input; a run starts only on its rising edge.
- cnt_out  input  1  datapath flag, 1 when the counter value is < 2.
- in_gt_12  input  1  datapath flag, 1 when the operand is > 12 (result would overflow 32 bits).
- control_signals  output  6  bit map: [5] en_D, [4] mux_s0, [3] mux_s1, [2] cnt_ld, [1] cnt_ud, [0] cnt_ce.
- busy  output  1  1 in LOAD, CHECK and MUL.
- done  output  1  1 in DONE; datapath result is valid.
- err  output  1  1 in ERR.
- timeout  output  1  1 in ERR when ERR was entered by the watchdog; 0 for operand-range errors.
- state  output  3  current state code, for debug.

Behaviour:
- Reset state: rst=1 forces IDLE. Iteration counter, go_q, timeout flag and all outputs go to 0. Reset takes effect immediately and may occur mid-run; the run is abandoned.
- Start pulse: go_q registers go. go_pulse = go & ~go_q. Holding go high never retriggers a run.
- State codes: IDLE=0, LOAD=1, CHECK=2, MUL=3, DONE=4, ERR=5. Codes 6 and 7 return to IDLE on the next edge with outputs 0.
- Datapath conventions: mux_s0=0 selects constant 1 into the D register; mux_s0=1 selects the product. mux_s1=0 drives result to 0; mux_s1=1 drives the D register to result. cnt_ud=0 counts down.
- Outputs are Moore only. control_signals per state:
  - IDLE: 000000.
  - LOAD: 100101 (en_D, cnt_ld, cnt_ce) — D<=1, counter<=operand.
  - CHECK: 000000.
  - MUL: 110001 (en_D, mux_s0, cnt_ce, cnt_ud=0) — D<=cnt*D and cnt<=cnt-1 in the same cycle.
  - DONE: 001000 (mux_s1).
  - ERR: 000000.
- IDLE: on go_pulse, go to ERR with timeout=0 if in_gt_12=1, else go to LOAD. Otherwise stay.
- LOAD: clear the iteration counter; go to CHECK unconditionally.
- CHECK: go to DONE if cnt_out=1. Else go to ERR with timeout=1 if iter==ITER_MAX. Else go to MUL.
- MUL: iter<=iter+1; go to CHECK.
- DONE and ERR: hold until go_pulse, then re-evaluate exactly as IDLE does (ERR or LOAD). The timeout flag updates only on entry to ERR.
- Latency: for operand n>=1, DONE is entered 2n+1 edges after the edge that samples go_pulse. For n=0 it is 3 edges; 0!=1 because D was loaded with 1. MUL is visited exactly max(n-1,0) times.
- Simultaneous events: in_gt_12 is sampled only on a go_pulse edge; changes during a run are ignored. go_pulse during LOAD, CHECK or MUL is ignored; the edge detector still tracks go.
- done, err and busy are mutually exclusive; exactly one of them or none (IDLE) is high.

Test Plan:
- Reset, then go 0->1 with operand 5 → DONE after 11 edges; 4 MUL visits; result 120; control_signals=001000, done=1, busy=0.
- Operand 0, then operand 1 → each reaches DONE in 3 edges with no MUL state; result 1.
- Operand 13 (in_gt_12=1), go edge → ERR on the next edge; err=1, timeout=0, result 0; a later go edge with operand 3 → DONE, result 6.
- cnt_out forced 0, ITER_MAX=15 → exactly 15 MUL visits, then ERR with timeout=1; control_signals=000000.
- go held high through DONE → no restart; go low then high → new run starts on that edge.
- rst asserted asynchronously mid-MUL with operand 12 → immediate IDLE; all outputs 0 before the next clk edge; a following run with operand 12 → result 479001600.
